btb_predictor: RTL and testbench

- Fetch-side branch target buffer with 2-bit saturating direction counters.
- Combinationally answers the fetch PC with a taken prediction and target. These drive the PC-select predict_taken and predicted-target inputs.
- Trained at the clock edge by the EX stage, which resolves branches and jumps.
- Sits between IF (lookup) and EX (update), and is the producer end of the predict/mispredict loop.

---
 rtl/btb_predictor_pkg.sv | 33 +++
 rtl/btb_predictor_if.sv | 26 ++
 rtl/btb_predictor_sat_ctr2.sv | 27 ++
 rtl/btb_predictor.sv | 93 +++++++++
 tb/tb_btb_predictor.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/btb_predictor_pkg.sv
// Shared types for the branch target buffer: direction counter encoding,
// stored entry layout and address-split helpers.
package btb_types;

  // Widest PC the entry layout can hold; narrower PCs are zero-extended.
  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_WIDTH-1:0] tag;
    logic [MAX_WIDTH-1:0] target;
    ctr_t                 ctr;
  } btb_entry_t;

  localparam ctr_t CTR_ALLOC_COND = WT;
  localparam ctr_t CTR_ALLOC_JAL  = ST;

  function automatic int idx_bits(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_bits(input int width, input int entries);
    return width - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch-lookup and EX-training signals of the branch target buffer.
// The master is the pipeline; the slave is the predictor.
interface btb_predictor_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] fetch_pc;
  logic             btb_hit;
  logic             predict_taken;
  logic [WIDTH-1:0] predict_target;
  logic             ex_update;
  logic [WIDTH-1:0] ex_pc;
  logic             ex_taken;
  logic [WIDTH-1:0] ex_target;
  logic             ex_uncond;
  logic             ex_jalr;

  modport master (
    output fetch_pc, ex_update, ex_pc, ex_taken, ex_target, ex_uncond, ex_jalr,
    input  btb_hit, predict_taken, predict_target
  );

  modport slave (
    input  fetch_pc, ex_update, ex_pc, ex_taken, ex_target, ex_uncond, ex_jalr,
    output btb_hit, predict_taken, predict_target
  );
endinterface

// File: rtl/btb_predictor_sat_ctr2.sv
// Next-state function of a 2-bit saturating direction counter.
// A jal forces the strongly-taken state regardless of history.
module sat_ctr2
  import btb_types::*;
(
  input  ctr_t ctr,
  input  logic taken,
  input  logic force_strong,
  output ctr_t ctr_next
);

  logic [1:0] ctr_bits;

  assign ctr_bits = ctr;

  always_comb begin
    ctr_next = ctr;
    if (force_strong) begin
      ctr_next = ST;
    end else if (taken) begin
      if (ctr != ST) ctr_next = ctr_t'(ctr_bits + 2'd1);
    end else begin
      if (ctr != SNT) ctr_next = ctr_t'(ctr_bits - 2'd1);
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer: combinational lookup for IF,
// single-port training from EX at the clock edge.
module btb_predictor
  import btb_types::*;
#(
  parameter int ENTRIES = 16,
  parameter int WIDTH   = 32
) (
  input logic           clk,
  input logic           rst,
  btb_predictor_if.slave bus
);

  localparam int IDX   = idx_bits(ENTRIES);
  localparam int TAG_W = tag_bits(WIDTH, ENTRIES);

  // Flops rather than RAM: lookup is asynchronous and reset clears every entry.
  btb_entry_t mem_reg [ENTRIES];

  logic [IDX-1:0]       fetch_idx;
  logic [IDX-1:0]       ex_idx;
  logic [MAX_WIDTH-1:0] fetch_tag;
  logic [MAX_WIDTH-1:0] ex_tag;
  btb_entry_t           fetch_entry;
  btb_entry_t           ex_entry;
  btb_entry_t           new_entry;
  logic                 fetch_hit;
  logic                 ex_hit;
  logic                 ex_take;
  logic                 upd_en;
  ctr_t                 ctr_next;
  logic [ENTRIES-1:0]   we_vec;
  logic                 unused_bits;

  assign fetch_idx   = bus.fetch_pc[IDX+1:2];
  assign ex_idx      = bus.ex_pc[IDX+1:2];
  assign fetch_tag   = MAX_WIDTH'(bus.fetch_pc[WIDTH-1:IDX+2]);
  assign ex_tag      = MAX_WIDTH'(bus.ex_pc[WIDTH-1:IDX+2]);
  assign fetch_entry = mem_reg[fetch_idx];
  assign ex_entry    = mem_reg[ex_idx];

  assign fetch_hit          = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
  assign bus.btb_hit        = fetch_hit;
  assign bus.predict_taken  = fetch_hit && fetch_entry.ctr[1];
  assign bus.predict_target = fetch_hit ? fetch_entry.target[WIDTH-1:0] : '0;

  assign ex_hit  = ex_entry.valid && (ex_entry.tag == ex_tag);
  assign ex_take = bus.ex_taken || bus.ex_uncond;
  // jalr targets are register-dependent, so they never enter the table.
  assign upd_en  = bus.ex_update && !bus.ex_jalr && (ex_hit || ex_take);

  sat_ctr2 u_sat_ctr2 (
    .ctr          (ex_entry.ctr),
    .taken        (bus.ex_taken),
    .force_strong (bus.ex_uncond),
    .ctr_next     (ctr_next)
  );

  always_comb begin
    new_entry = ex_entry;
    if (ex_hit) begin
      new_entry.ctr = ctr_next;
      if (ex_take) new_entry.target = MAX_WIDTH'(bus.ex_target);
    end else begin
      new_entry.valid  = 1'b1;
      new_entry.tag    = ex_tag;
      new_entry.target = MAX_WIDTH'(bus.ex_target);
      new_entry.ctr    = bus.ex_uncond ? CTR_ALLOC_JAL : CTR_ALLOC_COND;
    end
  end

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_we
      assign we_vec[gi] = upd_en && (ex_idx == IDX'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (we_vec[i]) mem_reg[i] <= new_entry;
      end
    end
  end

  // Byte offset and the weak/strong bit of the looked-up counter carry no information here.
  assign unused_bits = ^{bus.fetch_pc[1:0], bus.ex_pc[1:0], fetch_entry.ctr[0], TAG_W[0]};

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: per-cycle comparison against a
// table-of-branches model plus hand-computed lookup expectations.
module tb_btb_predictor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btb_predictor_if #(.WIDTH(32)) bus ();

  btb_predictor #(.ENTRIES(16), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;

  // Model: each slot remembers the PC of the branch that owns it.
  bit          m_valid [16];
  logic [31:0] m_pc    [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit mhit(input logic [31:0] pc);
    return m_valid[midx(pc)] && ((m_pc[midx(pc)] >> 6) == (pc >> 6));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] <= 1'b0;
        m_pc[i]    <= '0;
        m_tgt[i]   <= '0;
        m_ctr[i]   <= 0;
      end
    end else if (bus.ex_update && !bus.ex_jalr) begin
      if (mhit(bus.ex_pc)) begin
        if (bus.ex_uncond) begin
          m_ctr[midx(bus.ex_pc)] <= 3;
          m_tgt[midx(bus.ex_pc)] <= bus.ex_target;
        end else if (bus.ex_taken) begin
          m_ctr[midx(bus.ex_pc)] <= (m_ctr[midx(bus.ex_pc)] == 3) ? 3 : m_ctr[midx(bus.ex_pc)] + 1;
          m_tgt[midx(bus.ex_pc)] <= bus.ex_target;
        end else begin
          m_ctr[midx(bus.ex_pc)] <= (m_ctr[midx(bus.ex_pc)] == 0) ? 0 : m_ctr[midx(bus.ex_pc)] - 1;
        end
      end else if (bus.ex_taken || bus.ex_uncond) begin
        m_valid[midx(bus.ex_pc)] <= 1'b1;
        m_pc[midx(bus.ex_pc)]    <= bus.ex_pc;
        m_tgt[midx(bus.ex_pc)]   <= bus.ex_target;
        m_ctr[midx(bus.ex_pc)]   <= bus.ex_uncond ? 3 : 2;
      end
    end
  end

  logic        exp_hit;
  logic        exp_taken;
  logic [31:0] exp_tgt;

  always @(negedge clk) begin
    if (run_cmp) begin
      exp_hit   = mhit(bus.fetch_pc);
      exp_taken = exp_hit && (m_ctr[midx(bus.fetch_pc)] >= 2);
      exp_tgt   = exp_hit ? m_tgt[midx(bus.fetch_pc)] : 32'h0;
      checks++;
      if ({bus.btb_hit, bus.predict_taken, bus.predict_target} !== {exp_hit, exp_taken, exp_tgt}) begin
        failures++;
        $display("FAIL cycle_cmp pc=%h got hit=%b taken=%b tgt=%h want hit=%b taken=%b tgt=%h",
                 bus.fetch_pc, bus.btb_hit, bus.predict_taken, bus.predict_target,
                 exp_hit, exp_taken, exp_tgt);
      end
    end
  end

  task automatic chk3(input string name, input logic exp_h, input logic exp_t, input logic [31:0] exp_g);
    checks++;
    if ({bus.btb_hit, bus.predict_taken, bus.predict_target} !== {exp_h, exp_t, exp_g}) begin
      failures++;
      $display("FAIL %s pc=%h got hit=%b taken=%b tgt=%h want hit=%b taken=%b tgt=%h",
               name, bus.fetch_pc, bus.btb_hit, bus.predict_taken, bus.predict_target,
               exp_h, exp_t, exp_g);
    end else begin
      $display("ok   %s pc=%h hit=%b taken=%b tgt=%h", name, bus.fetch_pc,
               bus.btb_hit, bus.predict_taken, bus.predict_target);
    end
  endtask

  task automatic look(input logic [31:0] pc, input logic eh, input logic et,
                      input logic [31:0] eg, input string name);
    bus.fetch_pc  = pc;
    bus.ex_update = 1'b0;
    #1;
    chk3(name, eh, et, eg);
  endtask

  task automatic mctr(input logic [31:0] pc, input int want, input string name);
    checks++;
    if (m_ctr[midx(pc)] != want) begin
      failures++;
      $display("FAIL %s model ctr got=%0d want=%0d", name, m_ctr[midx(pc)], want);
    end else begin
      $display("ok   %s model ctr=%0d", name, want);
    end
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                        input logic unc, input logic jalr);
    bus.ex_update = 1'b1;
    bus.ex_pc     = pc;
    bus.ex_taken  = taken;
    bus.ex_target = tgt;
    bus.ex_uncond = unc;
    bus.ex_jalr   = jalr;
  endtask

  task automatic cyc(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic unc, input logic jalr);
    set_ex(pc, taken, tgt, unc, jalr);
    @(posedge clk);
    #1;
    bus.ex_update = 1'b0;
    $display("upd  pc=%h taken=%b tgt=%h uncond=%b jalr=%b", pc, taken, tgt, unc, jalr);
  endtask

  initial begin
    rst = 1'b1;
    bus.fetch_pc = '0;
    set_ex(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    bus.ex_update = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_cmp = 1'b1;

    look(32'h60, 1'b0, 1'b0, 32'h0, "reset_miss");

    cyc(32'h80, 1'b1, 32'h40, 1'b0, 1'b0);
    look(32'h80, 1'b1, 1'b1, 32'h40, "alloc_cond");
    mctr(32'h80, 2, "alloc_cond_ctr");

    cyc(32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    look(32'h80, 1'b1, 1'b0, 32'h40, "nt_weak");
    cyc(32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    look(32'h80, 1'b1, 1'b0, 32'h40, "sat_low");
    mctr(32'h80, 0, "sat_low_ctr");

    cyc(32'h80, 1'b1, 32'h44, 1'b0, 1'b0);
    look(32'h80, 1'b1, 1'b0, 32'h44, "taken_wnt");
    cyc(32'h80, 1'b1, 32'h44, 1'b0, 1'b0);
    look(32'h80, 1'b1, 1'b1, 32'h44, "taken_wt");

    cyc(32'h100, 1'b1, 32'h200, 1'b1, 1'b0);
    look(32'h100, 1'b1, 1'b1, 32'h200, "jal_alloc");
    look(32'h80, 1'b0, 1'b0, 32'h0, "alias_evict");
    mctr(32'h100, 3, "jal_ctr");
    cyc(32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
    cyc(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    look(32'h100, 1'b1, 1'b1, 32'h200, "sat_high");
    mctr(32'h100, 2, "sat_high_ctr");

    cyc(32'h140, 1'b1, 32'h10, 1'b0, 1'b0);
    look(32'h140, 1'b1, 1'b1, 32'h10, "replace_new");
    look(32'h100, 1'b0, 1'b0, 32'h0, "replace_old");

    cyc(32'h180, 1'b1, 32'h999, 1'b0, 1'b1);
    look(32'h180, 1'b0, 1'b0, 32'h0, "jalr_no_alloc");
    cyc(32'h140, 1'b0, 32'h0, 1'b0, 1'b1);
    look(32'h140, 1'b1, 1'b1, 32'h10, "jalr_no_train");

    cyc(32'h1C0, 1'b0, 32'h0, 1'b0, 1'b0);
    look(32'h1C0, 1'b0, 1'b0, 32'h0, "nt_no_alloc");
    look(32'h140, 1'b1, 1'b1, 32'h10, "nt_no_disturb");

    bus.fetch_pc = 32'h80;
    set_ex(32'h80, 1'b1, 32'h40, 1'b0, 1'b0);
    @(negedge clk);
    chk3("same_cycle_old", 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    bus.ex_update = 1'b0;
    look(32'h83, 1'b1, 1'b1, 32'h40, "next_cycle_hit");

    bus.fetch_pc = 32'h80;
    set_ex(32'h84, 1'b1, 32'h300, 1'b0, 1'b0);
    @(negedge clk);
    chk3("indep_lookup", 1'b1, 1'b1, 32'h40);
    @(posedge clk);
    #1;
    bus.ex_update = 1'b0;
    look(32'h84, 1'b1, 1'b1, 32'h300, "indep_alloc");

    look(32'h80, 1'b1, 1'b1, 32'h40, "pre_reset_hit");
    #1;
    rst = 1'b1;
    #1;
    chk3("async_rst", 1'b0, 1'b0, 32'h0);
    set_ex(32'h90, 1'b1, 32'h55, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.ex_update = 1'b0;
    rst = 1'b0;
    look(32'h90, 1'b0, 1'b0, 32'h0, "rst_discard_upd");
    look(32'h84, 1'b0, 1'b0, 32'h0, "rst_wipe");
    @(posedge clk);
    #1;

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
